// File: rtl/sipo_frame_controller_pkg.sv
// Shared definitions for the SIPO frame controller slice: FSM encoding and default word length.
package sipo_frame_controller_pkg;

    localparam int SIPO_WIDTH = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

endpackage : sipo_frame_controller_pkg

// File: rtl/sipo_frame_controller_shift_reg.sv
// Serial-in/parallel-out shift register; direction chosen by MSB_FIRST.
module sipo_shift_reg
    import sipo_frame_controller_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    // Shift one bit in when enabled; left shift fills bit 0, right shift fills the top bit
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], si};
            end else begin
                q <= {si, q[WIDTH-1:1]};
            end
        end
    end

endmodule : sipo_shift_reg

// File: rtl/sipo_frame_controller.sv
// Frame controller: gates serial bits into the SIPO, counts a word, and double-buffers it
// into a holding register offered downstream on a valid/ready handshake.
module sipo_frame_controller
    import sipo_frame_controller_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             si,
    input  logic             si_valid,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    sipo_state_t      state;
    sipo_state_t      state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             shift_en;
    logic             frame_done;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] word;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .clear (clear),
        .en    (shift_en),
        .si    (si),
        .q     (sh_q)
    );

    // The completed word must include the bit sampled this edge, so form it from the shifter's next value
    assign word = MSB_FIRST ? {sh_q[WIDTH-2:0], si} : {si, sh_q[WIDTH-1:1]};

    assign busy = (state == ST_SHIFT);

    // Next-state and bit-count logic; start restarts a frame and beats a concurrent si_valid
    always_comb begin
        state_next = state;
        count_next = count;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                    count_next = '0;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    count_next = '0;
                end else if (si_valid) begin
                    shift_en = 1'b1;
                    if (count == LAST_CNT) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // State and bit counter registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Holding register: load when free or being accepted this edge, otherwise drop the word and flag overrun
    always_ff @(posedge clk) begin
        if (clear) begin
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (frame_done) begin
            if (!po_valid || po_ready) begin
                po       <= word;
                po_valid <= 1'b1;
            end else begin
                overrun  <= 1'b1;
            end
        end else if (po_valid && po_ready) begin
            po_valid <= 1'b0;
        end
    end

endmodule : sipo_frame_controller

// File: tb/tb_sipo_frame_controller.sv
// Directed self-checking bench: a WIDTH=3 MSB-first instance and a WIDTH=4 LSB-first instance.
module tb_sipo_frame_controller;

    logic       clk;
    logic       clear;
    logic       start;
    logic       si;
    logic       si_valid;
    logic       po_ready;
    logic [2:0] po;
    logic       po_valid;
    logic       busy;
    logic       overrun;
    logic [3:0] po4;
    logic       po_valid4;
    logic       busy4;
    logic       overrun4;

    int errors = 0;
    int checks = 0;

    sipo_frame_controller #(.WIDTH(3), .MSB_FIRST(1'b1)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .si       (si),
        .si_valid (si_valid),
        .po       (po),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    sipo_frame_controller #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .si       (si),
        .si_valid (si_valid),
        .po       (po4),
        .po_valid (po_valid4),
        .po_ready (po_ready),
        .busy     (busy4),
        .overrun  (overrun4)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then wait past the edge so outputs are settled when checked
    task automatic applyStimulus(input logic c, input logic st, input logic s,
                                 input logic sv, input logic rdy);
        clear    = c;
        start    = st;
        si       = s;
        si_valid = sv;
        po_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value and count the result
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Directed test sequence
    initial begin
        clear = 1'b0; start = 1'b0; si = 1'b0; si_valid = 1'b0; po_ready = 1'b0;

        // 1: reset, then frame 1,0,1 MSB-first with no acceptance
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_po",       32'(po),       32'd0);
        checkOutput("rst_po_valid", 32'(po_valid), 32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_overrun",  32'(overrun),  32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t1_busy_start", 32'(busy), 32'd1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1_valid_early", 32'(po_valid), 32'd0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t1_po",       32'(po),       32'(3'b101));
        checkOutput("t1_po_valid", 32'(po_valid), 32'd1);
        checkOutput("t1_busy",     32'(busy),     32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t1_accept_valid", 32'(po_valid), 32'd0);
        checkOutput("t1_accept_po",    32'(po),       32'(3'b101));

        // 3: si_valid gaps: 1,(gap),1,(gap,gap),0
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t3_valid_gap", 32'(po_valid), 32'd0);
        checkOutput("t3_busy_gap",  32'(busy),     32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_po",       32'(po),       32'(3'b110));
        checkOutput("t3_po_valid", 32'(po_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);

        // 4: overrun: 011 held, 100 dropped, then accept; overrun stays sticky
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t4_first_po", 32'(po), 32'(3'b011));
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t4_po_kept",   32'(po),       32'(3'b011));
        checkOutput("t4_overrun",   32'(overrun),  32'd1);
        checkOutput("t4_busy",      32'(busy),     32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_hold_po",    32'(po),       32'(3'b011));
        checkOutput("t4_hold_valid", 32'(po_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t4_accept_valid",   32'(po_valid), 32'd0);
        checkOutput("t4_overrun_sticky", 32'(overrun),  32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_overrun_later",  32'(overrun),  32'd1);

        // 5: simultaneous accept and load
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t5_clear_overrun", 32'(overrun), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t5_first_po", 32'(po), 32'(3'b010));
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("t5_po",       32'(po),       32'(3'b111));
        checkOutput("t5_po_valid", 32'(po_valid), 32'd1);
        checkOutput("t5_overrun",  32'(overrun),  32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5_accept_valid", 32'(po_valid), 32'd0);

        // 6a: abort mid-frame with start (si at that edge ignored)
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t6_abort_busy",  32'(busy),     32'd1);
        checkOutput("t6_abort_valid", 32'(po_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t6_po",       32'(po),       32'(3'b001));
        checkOutput("t6_po_valid", 32'(po_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);

        // 6b: clear after two bits; no word emitted, stray si_valid in IDLE ignored
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("t6c_po",       32'(po),       32'd0);
        checkOutput("t6c_po_valid", 32'(po_valid), 32'd0);
        checkOutput("t6c_busy",     32'(busy),     32'd0);
        checkOutput("t6c_overrun",  32'(overrun),  32'd0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t6c_idle_valid", 32'(po_valid), 32'd0);
        checkOutput("t6c_idle_busy",  32'(busy),     32'd0);

        // 2: WIDTH=4 LSB-first instance, bits 1,0,1,1
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_busy", 32'(busy4), 32'd1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t2_valid_early", 32'(po_valid4), 32'd0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t2_po",       32'(po4),       32'(4'b1101));
        checkOutput("t2_po_valid", 32'(po_valid4), 32'd1);
        checkOutput("t2_overrun",  32'(overrun4),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sipo_frame_controller
